// File: rtl/divider_pkg.sv
// Shared constants for the port-mapped divider coprocessor: port map,
// command/status bit positions and the one-hot FSM encoding.
package divider_pkg;

  localparam logic [2:0] ADDR_X      = 3'd0;
  localparam logic [2:0] ADDR_Y      = 3'd1;
  localparam logic [2:0] ADDR_CMD    = 3'd2;
  localparam logic [2:0] ADDR_Q      = 3'd0;
  localparam logic [2:0] ADDR_R      = 3'd1;
  localparam logic [2:0] ADDR_STATUS = 3'd2;
  localparam logic [2:0] ADDR_XECHO  = 3'd3;
  localparam logic [2:0] ADDR_YECHO  = 3'd4;

  localparam int CMD_START_BIT = 0;
  localparam int CMD_ACK_BIT   = 1;

  localparam int STAT_QI_BIT = 0;
  localparam int STAT_QC_BIT = 1;
  localparam int STAT_QD_BIT = 2;
  localparam int STAT_DZ_BIT = 3;

  typedef enum logic [2:0] {
    ST_QI = 3'b001,
    ST_QC = 3'b010,
    ST_QD = 3'b100
  } state_e;

  function automatic logic [7:0] status_byte(input logic dz, input logic qd,
                                             input logic qc, input logic qi);
    logic [7:0] s;
    s = 8'h00;
    s[STAT_DZ_BIT] = dz;
    s[STAT_QD_BIT] = qd;
    s[STAT_QC_BIT] = qc;
    s[STAT_QI_BIT] = qi;
    return s;
  endfunction

endpackage

// File: rtl/divider_core.sv
// Repeated-subtraction divider FSM (QI -> QC -> QD) with its datapath and
// the result registers that only update on entry to QD.
module divider_core
  import divider_pkg::*;
(
  input  logic       board_clk,
  input  logic       Reset,
  input  logic       start_i,
  input  logic       ack_i,
  input  logic [7:0] x_i,
  input  logic [7:0] y_i,
  output logic [7:0] quotient_o,
  output logic [7:0] remainder_o,
  output logic       dz_o,
  output logic       qi_o,
  output logic       qc_o,
  output logic       qd_o
);

  state_e     state_q, state_d;
  logic [7:0] wd_q, wd_d;
  logic [7:0] wq_q, wq_d;
  logic [7:0] quot_q, quot_d;
  logic [7:0] rem_q, rem_d;
  logic       dz_q, dz_d;

  // State and datapath registers
  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_QI;
      wd_q    <= 8'h00;
      wq_q    <= 8'h00;
      quot_q  <= 8'h00;
      rem_q   <= 8'h00;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      wq_q    <= wq_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
    end
  end

  // Next-state and datapath update; START only counts in QI, ACK only in QD
  always_comb begin
    state_d = state_q;
    wd_d    = wd_q;
    wq_d    = wq_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    case (state_q)
      ST_QI: begin
        if (start_i) begin
          if (y_i != 8'h00) begin
            wd_d    = x_i;
            wq_d    = 8'h00;
            dz_d    = 1'b0;
            state_d = ST_QC;
          end else begin
            quot_d  = 8'hFF;
            rem_d   = x_i;
            dz_d    = 1'b1;
            state_d = ST_QD;
          end
        end else begin
          state_d = ST_QI;
        end
      end
      ST_QC: begin
        // y_i is stable here because X/Y writes are blocked outside QI
        if (wd_q >= y_i) begin
          wd_d = wd_q - y_i;
          wq_d = wq_q + 8'd1;
        end else begin
          quot_d  = wq_q;
          rem_d   = wd_q;
          state_d = ST_QD;
        end
      end
      ST_QD: begin
        if (ack_i) begin
          state_d = ST_QI;
        end else begin
          state_d = ST_QD;
        end
      end
      default: begin
        state_d = ST_QI;
      end
    endcase
  end

  assign quotient_o  = quot_q;
  assign remainder_o = rem_q;
  assign dz_o        = dz_q;
  assign qi_o        = state_q[STAT_QI_BIT];
  assign qc_o        = state_q[STAT_QC_BIT];
  assign qd_o        = state_q[STAT_QD_BIT];

endmodule

// File: rtl/divider_port_coproc.sv
// Processor-port wrapper: decodes OUTPUT/OUTPUTK writes into X, Y and command,
// and returns registered read data on in_port.
module divider_port_coproc
  import divider_pkg::*;
(
  input  logic       board_clk,
  input  logic       Reset,
  input  logic [7:0] port_id,
  input  logic [7:0] out_port,
  input  logic       write_strobe,
  input  logic       k_write_strobe,
  input  logic       read_strobe,
  output logic [7:0] in_port,
  output logic [7:0] quotient,
  output logic [7:0] remainder,
  output logic       qi,
  output logic       qc,
  output logic       qd,
  output logic       done,
  output logic       dz
);

  logic [7:0] x_q, x_d;
  logic [7:0] y_q, y_d;
  logic [7:0] in_port_q, in_port_d;
  logic       wr_s;
  logic       start_s;
  logic       ack_s;
  logic       unused_ok;

  assign wr_s      = write_strobe | k_write_strobe;
  assign start_s   = wr_s & (port_id[2:0] == ADDR_CMD) & out_port[CMD_START_BIT];
  assign ack_s     = wr_s & (port_id[2:0] == ADDR_CMD) & out_port[CMD_ACK_BIT];
  assign unused_ok = ^{read_strobe, port_id[7:3]};

  // Operand and read-data registers
  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      x_q       <= 8'h00;
      y_q       <= 8'h00;
      in_port_q <= 8'h00;
    end else begin
      x_q       <= x_d;
      y_q       <= y_d;
      in_port_q <= in_port_d;
    end
  end

  // Operand writes land only while idle
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (wr_s && qi) begin
      if (port_id[2:0] == ADDR_X) begin
        x_d = out_port;
      end else if (port_id[2:0] == ADDR_Y) begin
        y_d = out_port;
      end else begin
        x_d = x_q;
      end
    end else begin
      x_d = x_q;
    end
  end

  // Read mux, sampled every cycle regardless of read_strobe
  always_comb begin
    in_port_d = 8'h00;
    case (port_id[2:0])
      ADDR_Q:      in_port_d = quotient;
      ADDR_R:      in_port_d = remainder;
      ADDR_STATUS: in_port_d = status_byte(dz, qd, qc, qi);
      ADDR_XECHO:  in_port_d = x_q;
      ADDR_YECHO:  in_port_d = y_q;
      default:     in_port_d = 8'h00;
    endcase
  end

  divider_core u_core (
    .board_clk   (board_clk),
    .Reset       (Reset),
    .start_i     (start_s),
    .ack_i       (ack_s),
    .x_i         (x_q),
    .y_i         (y_q),
    .quotient_o  (quotient),
    .remainder_o (remainder),
    .dz_o        (dz),
    .qi_o        (qi),
    .qc_o        (qc),
    .qd_o        (qd)
  );

  assign in_port = in_port_q;
  assign done    = qd;

endmodule
